// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the parametrised CPU/slave memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    I_REQ = 2'd0,
    D_REQ = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of a counter that must hold values 0..timeout.
  function automatic int unsigned timeout_cnt_w(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_addr_decode_n.sv
// Combinational base/mask address decoder: lowest matching slave window wins.
module addr_decode_n
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned                        NUM_SLAVES = 4,
  parameter int unsigned                        ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]       SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]       SLAVE_MASK = '0
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  hit
);

  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (!hit && ((addr & SLAVE_MASK[k*ADDR_W +: ADDR_W]) == SLAVE_BASE[k*ADDR_W +: ADDR_W])) begin
        sel[k] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// Serialises one instruction fetch plus an optional data access per CPU cycle
// onto a shared req/ack slave bus, with unmapped/timeout error capture.
module mem_arbiter_n
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned                  NUM_SLAVES = 4,
  parameter int unsigned                  ADDR_W     = 32,
  parameter int unsigned                  DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
  parameter int unsigned                  TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            i_addr,
  output logic [DATA_W-1:0]            i_rdata,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [DATA_W-1:0]            d_wdata,
  input  logic                         d_we,
  input  logic                         d_re,
  output logic [DATA_W-1:0]            d_rdata,
  output logic                         cpu_stall,
  output logic [NUM_SLAVES-1:0]        s_req,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ack,
  output logic                         bus_err,
  output logic [ADDR_W-1:0]            err_addr
);

  localparam int unsigned      CNT_W  = timeout_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);

  state_t               state, next_state;
  logic                 armed, cur_hit;
  logic [CNT_W-1:0]     tcnt;
  logic                 launch, launch_d, finish;
  logic                 ack_sel, timed_out;
  logic [ADDR_W-1:0]    dec_addr;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                 dec_hit;
  logic [DATA_W-1:0]    rdata_sel;

  // s_req must be valid on the entry edge, so the decoder sees the address of
  // the access about to start: d_addr when leaving a completed fetch, else i_addr.
  assign launch_d = (state == I_REQ) && armed;
  assign dec_addr = launch_d ? d_addr : i_addr;

  addr_decode_n #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .addr (dec_addr),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  always_comb begin
    rdata_sel = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (s_req[k]) rdata_sel = rdata_sel | s_rdata[k*DATA_W +: DATA_W];
    end
  end

  // s_req is zero after an abort or reset, which masks late and stray acks.
  assign ack_sel   = |(s_ack & s_req);
  assign timed_out = cur_hit && !ack_sel && (tcnt == T_LAST);
  assign finish    = armed && (state != DONE) && (!cur_hit || ack_sel || timed_out);

  always_comb begin
    next_state = state;
    launch     = 1'b0;
    case (state)
      I_REQ: begin
        if (!armed) begin
          launch = 1'b1;
        end else if (finish) begin
          if (d_we || d_re) begin
            next_state = D_REQ;
            launch     = 1'b1;
          end else begin
            next_state = DONE;
          end
        end
      end
      D_REQ: begin
        if (finish) next_state = DONE;
      end
      DONE: begin
        next_state = I_REQ;
        launch     = 1'b1;
      end
      default: next_state = I_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= I_REQ;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_stall <= 1'b1;
      s_req     <= '0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      bus_err   <= 1'b0;
      err_addr  <= '0;
      tcnt      <= '0;
      armed     <= 1'b0;
      cur_hit   <= 1'b0;
    end else begin
      cpu_stall <= (next_state != DONE);

      if (finish) begin
        if (state == I_REQ) i_rdata <= ack_sel ? rdata_sel : '0;
        else if (!d_we)     d_rdata <= ack_sel ? rdata_sel : '0;
        if (!cur_hit || timed_out) begin
          bus_err <= 1'b1;
          if (!bus_err) err_addr <= s_addr;
        end
      end

      if (launch) begin
        s_req   <= dec_hit ? dec_sel : '0;
        s_addr  <= dec_addr;
        s_we    <= launch_d && d_we;
        if (launch_d) s_wdata <= d_wdata;
        cur_hit <= dec_hit;
        armed   <= 1'b1;
        tcnt    <= '0;
      end else if (finish) begin
        s_req <= '0;
        s_we  <= 1'b0;
      end else if (|s_req) begin
        tcnt <= tcnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n with latency-programmable slave models and
// a result scoreboard popped at each CPU-cycle boundary.
module tb_mem_arbiter_n;

  logic         clk, rst;
  logic [31:0]  i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic         d_we, d_re, cpu_stall;
  logic [3:0]   s_req, s_ack, force_ack;
  logic         s_we;
  logic [31:0]  s_addr, s_wdata, err_addr;
  logic [127:0] s_rdata;
  logic         bus_err;

  int           lat  [4];
  int           cnt  [4] = '{default: 0};
  logic [31:0]  rdat [4];

  int           n_cmp = 0;
  int           n_bad = 0;

  int           stall_n, we_n;
  int           req_n [4];
  logic [3:0]   req_or;
  logic [31:0]  addr_seen, wdata_seen;

  typedef struct {
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
    logic        bus_err;
    logic [31:0] err_addr;
  } exp_t;
  exp_t         sbq [$];
  logic [31:0]  m_i, m_d, m_ea;
  logic         m_err;

  mem_arbiter_n #(
    .NUM_SLAVES (4),
    .ADDR_W     (32),
    .DATA_W     (32),
    .SLAVE_BASE ({32'h2000_0000, 32'hF020_0000, 32'h2000_0000, 32'h0000_0000}),
    .SLAVE_MASK ({32'hFF00_0000, 32'hFFF0_0000, 32'hF000_0000, 32'hF000_0000}),
    .TIMEOUT    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_we      (d_we),
    .d_re      (d_re),
    .d_rdata   (d_rdata),
    .cpu_stall (cpu_stall),
    .s_req     (s_req),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .s_ack     (s_ack),
    .bus_err   (bus_err),
    .err_addr  (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave k acks in the lat[k]-th cycle of its request; lat 0 never acks.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (s_req[k] && !s_ack[k]) cnt[k] <= cnt[k] + 1;
      else                       cnt[k] <= 0;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      s_ack[k] = force_ack[k] | (s_req[k] && (lat[k] != 0) && (cnt[k] == lat[k] - 1));
      s_rdata[k*32 +: 32] = rdat[k];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.i_rdata  = m_i;
    e.d_rdata  = m_d;
    e.bus_err  = m_err;
    e.err_addr = m_ea;
    sbq.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sbq.size()), 32'd1);
      return;
    end
    e = sbq.pop_front();
    check({tag, "_i_rdata"},  i_rdata,        e.i_rdata);
    check({tag, "_d_rdata"},  d_rdata,        e.d_rdata);
    check({tag, "_bus_err"},  32'(bus_err),   32'(e.bus_err));
    check({tag, "_err_addr"}, err_addr,       e.err_addr);
  endtask

  // Runs one CPU cycle from a DONE (or reset) sample up to the next DONE sample.
  task automatic cpu_cycle(input int maxc, input int inj_at, input logic [3:0] inj_mask);
    stall_n    = 0;
    we_n       = 0;
    req_or     = '0;
    addr_seen  = '0;
    wdata_seen = '0;
    for (int k = 0; k < 4; k++) req_n[k] = 0;
    step();
    while (cpu_stall === 1'b1) begin
      stall_n++;
      force_ack = (stall_n == inj_at) ? inj_mask : 4'b0000;
      req_or = req_or | s_req;
      for (int k = 0; k < 4; k++) if (s_req[k]) req_n[k]++;
      if (|s_req) addr_seen = s_addr;
      if (s_we) begin
        we_n++;
        wdata_seen = s_wdata;
      end
      if (stall_n > maxc) begin
        check("cpu_cycle_bound", 32'(stall_n), 32'(maxc));
        force_ack = '0;
        return;
      end
      step();
    end
    force_ack = '0;
  endtask

  initial begin
    rst = 1'b1; i_addr = '0; d_addr = '0; d_wdata = '0; d_we = 1'b0; d_re = 1'b0;
    force_ack = '0;
    lat  = '{1, 1, 3, 1};
    rdat = '{32'h0, 32'h0, 32'h0, 32'h0};
    m_i = '0; m_d = '0; m_err = 1'b0; m_ea = '0;
    step();
    step();

    check("rst_stall",    32'(cpu_stall), 32'd1);
    check("rst_s_req",    32'(s_req),     32'd0);
    check("rst_bus_err",  32'(bus_err),   32'd0);
    check("rst_i_rdata",  i_rdata,        32'd0);

    // Warm-up fetch after reset
    rst = 1'b0; i_addr = 32'h20; rdat[0] = 32'hCAFE_F00D;
    m_i = 32'hCAFE_F00D; push_exp();
    cpu_cycle(10, 0, 4'b0);
    sb_check("warm");

    // Zero-wait fetch only
    i_addr = 32'h10; rdat[0] = 32'hDEAD_BEEF;
    m_i = 32'hDEAD_BEEF; push_exp();
    cpu_cycle(10, 0, 4'b0);
    check("fetch_stall",  32'(stall_n),   32'd1);
    check("fetch_req0",   32'(req_n[0]),  32'd1);
    check("fetch_addr",   addr_seen,      32'h10);
    check("fetch_done",   32'(cpu_stall), 32'd0);
    sb_check("fetch");

    // Fetch plus zero-wait load from slave 1
    i_addr = 32'h18; d_addr = 32'h2000_0040; d_re = 1'b1; rdat[1] = 32'hA5A5_A5A5;
    m_d = 32'hA5A5_A5A5; push_exp();
    cpu_cycle(10, 0, 4'b0);
    check("load_stall",   32'(stall_n),   32'd2);
    check("load_req1",    32'(req_n[1]),  32'd1);
    sb_check("load");

    // Store to latency-3 slave 2
    i_addr = 32'h14; d_addr = 32'hF020_0004; d_re = 1'b0; d_we = 1'b1; d_wdata = 32'h55;
    push_exp();
    cpu_cycle(20, 0, 4'b0);
    check("store_stall",  32'(stall_n),   32'd4);
    check("store_req2",   32'(req_n[2]),  32'd3);
    check("store_req_or", 32'(req_or),    32'b0101);
    check("store_we",     32'(we_n),      32'd3);
    check("store_wdata",  wdata_seen,     32'h55);
    sb_check("store");

    // Unmapped load
    i_addr = 32'h18; d_addr = 32'h8000_0000; d_we = 1'b0; d_re = 1'b1;
    m_d = '0; m_err = 1'b1; m_ea = 32'h8000_0000; push_exp();
    cpu_cycle(10, 0, 4'b0);
    check("unmap_stall",  32'(stall_n),   32'd2);
    check("unmap_req_or", 32'(req_or),    32'b0001);
    sb_check("unmap1");

    // Second unmapped load keeps the first error address
    d_addr = 32'h9000_0000; push_exp();
    cpu_cycle(10, 0, 4'b0);
    sb_check("unmap2");

    // Overlapping windows: slave 1 beats slave 3
    i_addr = 32'h40; d_addr = 32'h2000_0000; lat[1] = 2; rdat[1] = 32'h0BAD_F00D;
    m_d = 32'h0BAD_F00D; push_exp();
    cpu_cycle(10, 0, 4'b0);
    check("ovl_stall",    32'(stall_n),   32'd3);
    check("ovl_req_or",   32'(req_or),    32'b0011);
    check("ovl_req1",     32'(req_n[1]),  32'd2);
    check("ovl_req3",     32'(req_n[3]),  32'd0);
    sb_check("ovl");

    // Write and read both requested: handled as a write
    i_addr = 32'h44; d_addr = 32'h100; d_we = 1'b1; d_re = 1'b1; d_wdata = 32'h99;
    push_exp();
    cpu_cycle(10, 0, 4'b0);
    check("wr_rd_stall",  32'(stall_n),   32'd2);
    check("wr_rd_we",     32'(we_n),      32'd1);
    check("wr_rd_wdata",  wdata_seen,     32'h99);
    sb_check("wr_rd");

    // Reset in the middle of a latency-5 fetch
    d_we = 1'b0; d_re = 1'b0; lat[0] = 5; i_addr = 32'h30;
    step();
    check("mid_s_req",    32'(s_req),     32'b0001);
    step();
    step();
    rst = 1'b1;
    step();
    check("mrst_stall",   32'(cpu_stall), 32'd1);
    check("mrst_s_req",   32'(s_req),     32'd0);
    check("mrst_s_we",    32'(s_we),      32'd0);
    check("mrst_s_addr",  s_addr,         32'd0);
    check("mrst_s_wdata", s_wdata,        32'd0);
    check("mrst_i_rdata", i_rdata,        32'd0);
    check("mrst_d_rdata", d_rdata,        32'd0);
    check("mrst_bus_err", 32'(bus_err),   32'd0);
    check("mrst_err_addr", err_addr,      32'd0);
    rst = 1'b0; force_ack = 4'b0001; rdat[0] = 32'hFFFF_FFFF;
    step();
    force_ack = '0; rdat[0] = 32'h1111_2222; lat[0] = 1;
    check("late_ack_i_rdata", i_rdata,    32'd0);
    m_i = 32'h1111_2222; m_d = '0; m_err = 1'b0; m_ea = '0; push_exp();
    step();
    check("post_rst_done", 32'(cpu_stall), 32'd0);
    sb_check("post_rst");

    // Timeout on a slave that never acks
    i_addr = 32'h2000_0100; lat[1] = 0;
    m_i = '0; m_err = 1'b1; m_ea = 32'h2000_0100; push_exp();
    cpu_cycle(30, 0, 4'b0);
    check("to_stall",     32'(stall_n),   32'd8);
    check("to_req1",      32'(req_n[1]),  32'd8);
    check("to_req_low",   32'(s_req),     32'd0);
    sb_check("timeout");

    // Stray ack from the aborted slave two clocks later is ignored
    i_addr = 32'h50; lat[0] = 3; rdat[0] = 32'h7777_8888; rdat[1] = 32'hBAD0_BAD0;
    m_i = 32'h7777_8888; push_exp();
    cpu_cycle(10, 1, 4'b0010);
    check("stray_stall",  32'(stall_n),   32'd3);
    check("stray_req0",   32'(req_n[0]),  32'd3);
    check("stray_req1",   32'(req_n[1]),  32'd0);
    sb_check("stray");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
